// File: rtl/hierInclude_package.sv
// Shared link payload types plus b2c_responder op/status encodings.
// Imported by the req_ack_if link, b2c_regfile and b2c_responder.
package hierInclude_package;

  localparam int B2C_ADDR_W = 8;
  localparam int B2C_DATA_W = 32;

  typedef struct packed {
    logic [1:0]            op;
    logic [B2C_ADDR_W-1:0] addr;
    logic [B2C_DATA_W-1:0] wdata;
  } anotherSt;

  typedef struct packed {
    logic [1:0]            status;
    logic [B2C_DATA_W-1:0] rdata;
  } yetAnotherSt;

  typedef enum logic [1:0] {
    B2C_READ  = 2'd0,
    B2C_WRITE = 2'd1,
    B2C_INCR  = 2'd2,
    B2C_CLEAR = 2'd3
  } b2cOpT;

  typedef enum logic [1:0] {
    B2C_OK       = 2'd0,
    B2C_ERR_ADDR = 2'd2
  } b2cStatusT;

endpackage

// File: rtl/req_ack_if.sv
// Four-phase req/ack link; initiator holds req and data until it sees ack.
interface req_ack_if #(
  parameter type data_t  = logic,
  parameter type rdata_t = logic
);
  logic   req;
  data_t  data;
  logic   ack;
  rdata_t rdata;

  modport master (output req, output data, input ack, input rdata);
  modport slave  (input req, input data, output ack, output rdata);
endinterface

// File: rtl/b2c_regfile.sv
// DEPTH x 32 register file: combinational read, synchronous write,
// synchronous active-low clear of every entry.
module b2c_regfile
  import hierInclude_package::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [B2C_DATA_W-1:0] wdata,
  output logic [B2C_DATA_W-1:0] rdata
);

  logic [B2C_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/b2c_responder.sv
// Target end of a req_ack_if link executing READ/WRITE/INCR/CLEAR on b2c_regfile.
// Optional saturating req/err counters when B2C_RESP_STATS_EN is defined.
//
// state     | meaning
// IDLE      | waiting for req, captures the payload
// PROCESS   | latency countdown; op executes when counter hits 0
// ACK       | one-cycle ack with the result
// WAIT_DROP | waiting for initiator to release req
module b2c_responder
  import hierInclude_package::*;
#(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  req_ack_if.slave  b2C
`ifdef B2C_RESP_STATS_EN
  ,
  output logic [15:0] req_count,
  output logic [15:0] err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [B2C_ADDR_W:0] DEPTH_L = (B2C_ADDR_W+1)'(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PROCESS   = 2'd1;
  localparam logic [1:0] ACK       = 2'd2;
  localparam logic [1:0] WAIT_DROP = 2'd3;

  logic [1:0]            state;
  logic [3:0]            cnt;
  anotherSt              req_q;
  yetAnotherSt           result_q;
  logic                  ack_q;
  yetAnotherSt           rdata_q;

  logic                  fire;
  logic                  addr_err;
  logic                  rf_we;
  logic [B2C_DATA_W-1:0] rf_wdata;
  logic [B2C_DATA_W-1:0] rf_rdata;
  yetAnotherSt           result_d;

  assign fire     = (state == PROCESS) && (cnt == '0);
  assign addr_err = {1'b0, req_q.addr} >= DEPTH_L;

  b2c_regfile #(.DEPTH(DEPTH)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .addr  (req_q.addr[AW-1:0]),
    .wdata (rf_wdata),
    .rdata (rf_rdata)
  );

  always_comb begin
    rf_we           = 1'b0;
    rf_wdata        = '0;
    result_d.status = B2C_OK;
    result_d.rdata  = '0;
    if (addr_err) begin
      result_d.status = B2C_ERR_ADDR;
    end else begin
      case (b2cOpT'(req_q.op))
        B2C_READ:  result_d.rdata = rf_rdata;
        B2C_WRITE: begin
          rf_we          = fire;
          rf_wdata       = req_q.wdata;
          result_d.rdata = req_q.wdata;
        end
        B2C_INCR: begin
          rf_we          = fire;
          rf_wdata       = rf_rdata + req_q.wdata;
          result_d.rdata = rf_wdata;
        end
        default: begin
          rf_we          = fire;
          rf_wdata       = '0;
          result_d.rdata = rf_rdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      req_q    <= '0;
      result_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: if (b2C.req) begin
          req_q <= b2C.data;
          cnt   <= 4'(LATENCY - 1);
          state <= PROCESS;
        end
        PROCESS: begin
          if (cnt == '0) begin
            result_q <= result_d;
            state    <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          ack_q   <= 1'b1;
          rdata_q <= result_q;
          state   <= WAIT_DROP;
        end
        default: if (!b2C.req) state <= IDLE;
      endcase
    end
  end

  assign b2C.ack   = ack_q;
  assign b2C.rdata = rdata_q;

`ifdef B2C_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_count <= '0;
      err_count <= '0;
    end else if (state == ACK) begin
      if (req_count != 16'hFFFF) req_count <= req_count + 16'd1;
      if (result_q.status == B2C_ERR_ADDR && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_b2c_responder.sv
// Directed bench for b2c_responder (DEPTH=8, LATENCY=2); hand-computed expectations.
module tb_b2c_responder;
  import hierInclude_package::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [1:0]  st;
  logic [31:0] rd;
  int          lat;

  req_ack_if #(.data_t(anotherSt), .rdata_t(yetAnotherSt)) b2C ();

`ifdef B2C_RESP_STATS_EN
  logic [15:0] req_count;
  logic [15:0] err_count;
`endif

  b2c_responder #(.DEPTH(8), .LATENCY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .b2C   (b2C.slave)
`ifdef B2C_RESP_STATS_EN
    ,
    .req_count (req_count),
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request, counts negedges until ack (bounded), then drops req
  // and spends one cycle so the responder returns to IDLE.
  task automatic xact(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd,
                      input bit scramble,
                      output logic [1:0] s, output logic [31:0] r, output int n);
    b2C.data = '{op: op, addr: addr, wdata: wd};
    b2C.req  = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (scramble && n == 1) b2C.data = '{op: 2'(op + 2'd1), addr: addr ^ 8'h1, wdata: ~wd};
      if (b2C.ack) break;
    end
    {s, r} = b2C.rdata;
    b2C.req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    b2C.req     = 1'b0;
    b2C.data    = '0;
    repeat (2) @(negedge clk);
    chk("reset_ack", 64'(b2C.ack), 64'd0);
    chk("reset_rdata", 64'(b2C.rdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    xact(2'd1, 8'd3, 32'hDEADBEEF, 0, st, rd, lat);
    chk("wr3_lat", 64'(lat), 64'd4);
    chk("wr3_status", 64'(st), 64'd0);
    chk("wr3_rdata", 64'(rd), 64'hDEADBEEF);
    chk("ack_one_cycle", 64'(b2C.ack), 64'd0);
    chk("rdata_hold", 64'(b2C.rdata[31:0]), 64'hDEADBEEF);
    xact(2'd0, 8'd3, 32'h0, 0, st, rd, lat);
    chk("rd3_lat", 64'(lat), 64'd4);
    chk("rd3_rdata", 64'(rd), 64'hDEADBEEF);

    xact(2'd1, 8'd5, 32'hFFFFFFFF, 0, st, rd, lat);
    xact(2'd2, 8'd5, 32'd2, 0, st, rd, lat);
    chk("incr5_status", 64'(st), 64'd0);
    chk("incr5_wrap", 64'(rd), 64'h1);
    xact(2'd0, 8'd5, 32'h0, 0, st, rd, lat);
    chk("rd5", 64'(rd), 64'h1);

    xact(2'd0, 8'd8, 32'h0, 0, st, rd, lat);
    chk("rd8_status", 64'(st), 64'd2);
    chk("rd8_rdata", 64'(rd), 64'd0);
`ifdef B2C_RESP_STATS_EN
    chk("err_count", 64'(err_count), 64'd1);
    chk("req_count", 64'(req_count), 64'd6);
`endif
    xact(2'd1, 8'd200, 32'h12345678, 0, st, rd, lat);
    chk("wr200_status", 64'(st), 64'd2);
    chk("wr200_rdata", 64'(rd), 64'd0);
    xact(2'd0, 8'd0, 32'h0, 0, st, rd, lat);
    chk("rd0_no_alias", 64'(rd), 64'd0);
    xact(2'd0, 8'd3, 32'h0, 0, st, rd, lat);
    chk("rd3_unchanged", 64'(rd), 64'hDEADBEEF);
    xact(2'd1, 8'd7, 32'hA5A5A5A5, 0, st, rd, lat);
    xact(2'd0, 8'd7, 32'h0, 0, st, rd, lat);
    chk("rd7_top", 64'(rd), 64'hA5A5A5A5);
    chk("rd7_status", 64'(st), 64'd0);

    // Initiator keeps req high after ack: only one ack, then a clean restart.
    b2C.data = '{op: 2'd1, addr: 8'd6, wdata: 32'h11};
    b2C.req  = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (b2C.ack) break;
    end
    chk("hold_first_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_no_reack", 64'(b2C.ack), 64'd0);
    end
    b2C.req = 1'b0;
    @(negedge clk);
    xact(2'd0, 8'd6, 32'h0, 0, st, rd, lat);
    chk("after_hold_lat", 64'(lat), 64'd4);
    chk("after_hold_rd6", 64'(rd), 64'h11);

    xact(2'd1, 8'd2, 32'h55, 0, st, rd, lat);
    xact(2'd3, 8'd2, 32'hFFFF, 0, st, rd, lat);
    chk("clr2_old", 64'(rd), 64'h55);
    xact(2'd0, 8'd2, 32'h0, 0, st, rd, lat);
    chk("rd2_cleared", 64'(rd), 64'd0);

    // Payload changes after capture must be ignored.
    xact(2'd1, 8'd4, 32'hCAFE0001, 1, st, rd, lat);
    chk("scr_lat", 64'(lat), 64'd4);
    chk("scr_rdata", 64'(rd), 64'hCAFE0001);
    xact(2'd0, 8'd4, 32'h0, 0, st, rd, lat);
    chk("rd4_captured", 64'(rd), 64'hCAFE0001);
    xact(2'd0, 8'd5, 32'h0, 0, st, rd, lat);
    chk("rd5_untouched", 64'(rd), 64'h1);

    // Reset while a WRITE to addr 1 sits in PROCESS.
    b2C.data = '{op: 2'd1, addr: 8'd1, wdata: 32'h77};
    b2C.req  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n   = 1'b0;
    b2C.req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid_ack", 64'(b2C.ack), 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_ack", 64'(b2C.ack), 64'd0);
    end
    xact(2'd0, 8'd1, 32'h0, 0, st, rd, lat);
    chk("rd1_after_rst", 64'(rd), 64'd0);
    chk("rd1_lat", 64'(lat), 64'd4);
    xact(2'd0, 8'd3, 32'h0, 0, st, rd, lat);
    chk("rd3_cleared_by_rst", 64'(rd), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
